erasure_flag_ctrl: RTL and testbench

ERASURE_FLAG_CTRL -- requirements
Module: erasure_flag_ctrl

---
 rtl/rs_decoder_pkg.sv | 13 +
 rtl/erasure_flag_ram.sv | 21 ++
 rtl/erasure_flag_ctrl.sv | 163 ++++++++++++++++
 tb/tb_erasure_flag_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rs_decoder_pkg.sv
// Shared types and widths for the RS decoder erasure path.
package rs_decoder_pkg;

  localparam int ADDR_W  = 8;
  localparam int COUNT_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } efc_state_e;

endpackage

// File: rtl/erasure_flag_ram.sv
// 256x1 simple dual-port flag store; registered read that holds its output while rd_en is low.
module erasure_flag_ram
  import rs_decoder_pkg::*;
(
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data
);

  logic mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/erasure_flag_ctrl.sv
// Buffers one codeword of erasure flags, reports the erasure count, then drains the flags in order.
// Optional macro ERASURE_FLAG_CTRL_OVERFLOW_EN: flag overflow and suppress erasures of overflowed codewords.
module erasure_flag_ctrl
  import rs_decoder_pkg::*;
#(
  parameter int N            = 255,
  parameter int MAX_ERASURES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_erasure,
  input  logic               in_last,
  output logic               count_valid,
  output logic [COUNT_W-1:0] erasure_count,
  output logic               overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_erasure,
  output logic               out_last
);

  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(N - 1);
  localparam logic [COUNT_W-1:0] ONE      = COUNT_W'(1);
`ifdef ERASURE_FLAG_CTRL_OVERFLOW_EN
  localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_ERASURES);
`endif

  efc_state_e         state_q, state_d;
  logic [COUNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] erasure_count_q, erasure_count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               count_valid_q, count_valid_d;
  logic               overflow_q, overflow_d;

  logic               accept, final_accept, ram_wr_en, ram_rd_en, ram_rd_data;
  logic [COUNT_W-1:0] err_total;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    err_cnt_d       = err_cnt_q;
    len_d           = len_q;
    rd_ptr_d        = rd_ptr_q;
    erasure_count_d = erasure_count_q;
    in_ready_d      = in_ready_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    count_valid_d   = 1'b0;
    overflow_d      = overflow_q;
    ram_wr_en       = 1'b0;
    ram_rd_en       = 1'b0;

    accept       = in_valid && in_ready_q;
    final_accept = accept && (in_last || wr_ptr_q == LAST_IDX);
    err_total    = err_cnt_q + COUNT_W'(in_erasure);

    case (state_q)
      IDLE, FILL: begin
        in_ready_d = 1'b1;
        if (accept) begin
          ram_wr_en = 1'b1;
          wr_ptr_d  = wr_ptr_q + ONE;
          err_cnt_d = err_total;
          state_d   = FILL;
        end
        // Closing the codeword publishes the count and rewinds the fill side for the next one.
        if (final_accept) begin
          state_d         = DRAIN;
          in_ready_d      = 1'b0;
          len_d           = wr_ptr_q + ONE;
          wr_ptr_d        = '0;
          err_cnt_d       = '0;
          rd_ptr_d        = '0;
          erasure_count_d = err_total;
          count_valid_d   = 1'b1;
`ifdef ERASURE_FLAG_CTRL_OVERFLOW_EN
          overflow_d      = err_total > MAX_CNT;
`else
          overflow_d      = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) begin
          if (rd_ptr_q != len_q) begin
            ram_rd_en   = 1'b1;
            rd_ptr_d    = rd_ptr_q + ONE;
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q + ONE == len_q);
          end else begin
            out_valid_d = 1'b0;
          end
        end
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rd_ptr_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      err_cnt_q       <= '0;
      len_q           <= '0;
      rd_ptr_q        <= '0;
      erasure_count_q <= '0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      count_valid_q   <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      err_cnt_q       <= err_cnt_d;
      len_q           <= len_d;
      rd_ptr_q        <= rd_ptr_d;
      erasure_count_q <= erasure_count_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      count_valid_q   <= count_valid_d;
      overflow_q      <= overflow_d;
    end
  end

  erasure_flag_ram u_ram (
    .clock   (clock),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (in_erasure),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  assign in_ready      = in_ready_q;
  assign count_valid   = count_valid_q;
  assign erasure_count = erasure_count_q;
  assign overflow      = overflow_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
`ifdef ERASURE_FLAG_CTRL_OVERFLOW_EN
  assign out_erasure   = ram_rd_data & ~overflow_q;
`else
  assign out_erasure   = ram_rd_data;
`endif

endmodule

// File: tb/tb_erasure_flag_ctrl.sv
// Scoreboard bench for erasure_flag_ctrl; expectations follow ERASURE_FLAG_CTRL_OVERFLOW_EN if defined.
module tb_erasure_flag_ctrl;
  import rs_decoder_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0, in_erasure = 1'b0, in_last = 1'b0;
  logic               in_ready, count_valid, overflow, out_valid, out_erasure, out_last;
  logic               out_ready = 1'b1;
  logic [COUNT_W-1:0] erasure_count;

  int  tests = 0, fails = 0, rx_count = 0, ready_mode = 0;
  bit  pat [256];
  logic [9:0] exp_cnt [$];
  logic [1:0] exp_out [$];

  erasure_flag_ctrl #(.N(255), .MAX_ERASURES(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_erasure(in_erasure), .in_last(in_last), .count_valid(count_valid),
    .erasure_count(erasure_count), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_erasure(out_erasure), .out_last(out_last)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pushes the expected count and drained flags, then feeds the codeword honouring in_ready.
  task automatic applyStimulus(input int len, input bit use_last);
    int  cnt = 0;
    bit  ovf;
    for (int i = 0; i < len; i++) cnt += pat[i];
`ifdef ERASURE_FLAG_CTRL_OVERFLOW_EN
    ovf = (cnt > 16);
`else
    ovf = 1'b0;
`endif
    exp_cnt.push_back({ovf, cnt[8:0]});
    for (int i = 0; i < len; i++) exp_out.push_back({pat[i] & ~ovf, i == len - 1});
    for (int i = 0; i < len; i++) begin
      int tmo = 0;
      @(negedge clock);
      in_valid   = 1'b1;
      in_erasure = pat[i];
      in_last    = use_last && (i == len - 1);
      while (!in_ready && tmo < 1000) begin @(negedge clock); tmo++; end
      if (tmo >= 1000) checkOutput("in_ready_timeout", 16'(in_ready), 16'd1);
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0; in_erasure = 1'b0;
    checkOutput("in_ready_drain", 16'(in_ready), 16'd0);
    checkOutput("out_valid_lat1", 16'(out_valid), 16'd0);
    @(negedge clock);
    checkOutput("out_valid_lat2", 16'(out_valid), 16'd1);
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while ((exp_out.size() != 0 || exp_cnt.size() != 0) && cyc < 3000) begin
      @(negedge clock); cyc++;
    end
    checkOutput("drain_done", 16'(exp_out.size() + exp_cnt.size()), 16'd0);
    @(negedge clock); @(negedge clock);
    checkOutput("idle_ready", 16'(in_ready), 16'd1);
  endtask

  // out_ready changes just after the rising edge so the monitor never races it.
  always @(posedge clock) begin
    #2;
    if (ready_mode == 0) out_ready = 1'b1;
    else out_ready = (($urandom_range(0, 3) == 0) || ($urandom_range(0, 3) == 3));
  end

  // Monitor: pops expectations whenever the DUT presents a count or completes an output handshake.
  initial begin : monitor
    bit         prev_stall = 1'b0;
    logic [1:0] prev_val   = 2'b00;
    logic [9:0] ec;
    logic [1:0] eo;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_valid", 16'(out_valid), 16'd1);
          checkOutput("stall_hold", 16'({out_erasure, out_last}), 16'(prev_val));
        end
        if (count_valid) begin
          if (exp_cnt.size() == 0) checkOutput("unexpected_count", 16'd1, 16'd0);
          else begin
            ec = exp_cnt.pop_front();
            checkOutput("erasure_count", 16'(erasure_count), 16'(ec[8:0]));
            checkOutput("overflow", 16'(overflow), 16'(ec[9]));
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) checkOutput("unexpected_out", 16'd1, 16'd0);
          else begin
            eo = exp_out.pop_front();
            checkOutput("out_flag", 16'({out_erasure, out_last}), 16'(eo));
            rx_count++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = {out_erasure, out_last};
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int cyc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_out_last", 16'(out_last), 16'd0);
    checkOutput("rst_count_valid", 16'(count_valid), 16'd0);
    checkOutput("rst_erasure_count", 16'(erasure_count), 16'd0);
    checkOutput("rst_overflow", 16'(overflow), 16'd0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) pat[i] = (i == 3 || i == 100 || i == 254);
    applyStimulus(255, 1'b1);
    waitDrain();

    for (int i = 0; i < 256; i++) pat[i] = 1'b1;
    applyStimulus(20, 1'b1);
    waitDrain();

    ready_mode = 1;
    for (int i = 0; i < 256; i++) pat[i] = (i % 3 == 0);
    applyStimulus(40, 1'b1);
    waitDrain();
    ready_mode = 0;

    pat[0] = 1'b1;
    applyStimulus(1, 1'b1);
    waitDrain();

    // 255 flags with no in_last close on length; reset lands after 50 drained flags.
    for (int i = 0; i < 256; i++) pat[i] = (i % 7 == 0);
    rx_count = 0;
    applyStimulus(255, 1'b0);
    cyc = 0;
    while (rx_count < 50 && cyc < 1000) begin @(negedge clock); cyc++; end
    checkOutput("mid_drain_reached", 16'(rx_count >= 50), 16'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("mid_rst_in_ready", 16'(in_ready), 16'd0);
    checkOutput("mid_rst_count", 16'(erasure_count), 16'd0);
    exp_out.delete();
    exp_cnt.delete();
    reset = 1'b0;

    for (int i = 0; i < 256; i++) pat[i] = i[0];
    applyStimulus(10, 1'b1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
